// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// the accept-time legality check for an access.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR      = 3'd3,
      RESP    = 3'd4
   } lsu_state_t;

   // Unsigned variants exist only for loads; halves and words must be naturally aligned.
   function automatic logic access_ok(input logic store, input logic [2:0] funct3,
                                      input logic [1:0] lane);
      logic ok;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~lane[0];
         F3_W:    ok = (lane == 2'b00);
         F3_BU:   ok = ~store;
         F3_HU:   ok = ~store & ~lane[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response, Registers write port and Memory bus of the load/store unit.
// The unit itself uses the slave modport; the surrounding system uses master.
interface lsu_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_store_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [4:0]  req_rd_i;
   logic        resp_valid_o;
   logic        resp_err_o;
   logic        rf_wr_en_o;
   logic [4:0]  rf_rd_addr_o;
   logic [31:0] rf_data_o;
   logic        mem_rd_en_o;
   logic        mem_wr_en_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        mem_ack_i;

   modport slave (
      input  req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
             mem_data_i, mem_ack_i,
      output req_ready_o, resp_valid_o, resp_err_o, rf_wr_en_o, rf_rd_addr_o, rf_data_o,
             mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
   );

   modport master (
      output req_valid_i, req_store_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
             mem_data_i, mem_ack_i,
      input  req_ready_o, resp_valid_o, resp_err_o, rf_wr_en_o, rf_rd_addr_o, rf_data_o,
             mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: extracts and extends load data, and
// merges sub-word store data into a read word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] ld_val,
   output logic [31:0] st_word
);

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sx);
      logic signed [31:0] s;
      s = 32'(signed'(b));
      return sx ? s : {24'b0, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sx);
      logic signed [31:0] s;
      s = 32'(signed'(h));
      return sx ? s : {16'b0, h};
   endfunction

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   assign sel_byte = word[{lane, 3'b000} +: 8];
   assign sel_half = word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      ld_val = word;
      case (funct3)
         F3_B:    ld_val = ext_byte(sel_byte, 1'b1);
         F3_BU:   ld_val = ext_byte(sel_byte, 1'b0);
         F3_H:    ld_val = ext_half(sel_half, 1'b1);
         F3_HU:   ld_val = ext_half(sel_half, 1'b0);
         default: ld_val = word;
      endcase
   end

   // Lanes other than the addressed one keep their read-back value.
   always_comb begin
      st_word = word;
      case (funct3[1:0])
         2'b00:   st_word[{lane, 3'b000} +: 8]     = wdata[7:0];
         2'b01:   st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: st_word = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer between execute and a single-port word Memory;
// sub-word stores are done as read-modify-write since Memory has no byte enables.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic  clk,
   input  logic  rst_n,
   lsu_if.slave  bus
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   lsu_state_t state_q, state_d;

   logic             store_q;
   logic             err_q;
   logic [CNT_W-1:0] tmo_cnt_q;

   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic [31:0] wdata_q;
   logic [4:0]  rd_q;
   logic [31:0] load_q;
   logic [31:0] wr_word_q;

   logic        accept;
   logic        req_ok;
   logic        req_sw;
   logic        tmo_hit;
   logic [31:0] ld_val;
   logic [31:0] st_word;

   assign accept  = bus.req_valid_i && (state_q == IDLE);
   assign req_ok  = access_ok(bus.req_store_i, bus.req_funct3_i, bus.req_addr_i[1:0]);
   assign req_sw  = bus.req_store_i && (bus.req_funct3_i == F3_W);
   assign tmo_hit = (tmo_cnt_q == CNT_LAST);

   lsu_align u_align (
      .word    (bus.mem_data_i),
      .lane    (addr_q[1:0]),
      .funct3  (funct3_q),
      .wdata   (wdata_q),
      .ld_val  (ld_val),
      .st_word (st_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!req_ok)     state_d = RESP;
               else if (req_sw) state_d = WR;
               else             state_d = RD_REQ;
            end
         end
         RD_REQ:  state_d = RD_WAIT;
         RD_WAIT: begin
            if (bus.mem_ack_i) state_d = store_q ? WR : RESP;
            else if (tmo_hit)  state_d = RESP;
         end
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state: cleared by reset so an aborted access leaves nothing pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q   <= 1'b0;
         err_q     <= 1'b0;
         tmo_cnt_q <= '0;
      end else begin
         if (accept) begin
            store_q <= bus.req_store_i;
            err_q   <= ~req_ok;
         end
         if (state_q == RD_REQ) begin
            tmo_cnt_q <= '0;
         end else if (state_q == RD_WAIT && !bus.mem_ack_i) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_hit) err_q <= 1'b1;
         end
      end
   end

   // Datapath latches: only ever observed through state-gated outputs.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q   <= bus.req_addr_i;
         funct3_q <= bus.req_funct3_i;
         wdata_q  <= bus.req_wdata_i;
         rd_q     <= bus.req_rd_i;
         if (req_sw) wr_word_q <= bus.req_wdata_i;
      end
      if (state_q == RD_WAIT && bus.mem_ack_i) begin
         load_q    <= ld_val;
         wr_word_q <= st_word;
      end
   end

   logic load_done;
   assign load_done = (state_q == RESP) && !store_q && !err_q;

   always_comb begin
      bus.req_ready_o  = (state_q == IDLE);
      bus.mem_rd_en_o  = (state_q == RD_REQ);
      bus.mem_wr_en_o  = (state_q == WR);
      bus.mem_addr_o   = '0;
      bus.mem_data_o   = '0;
      bus.resp_valid_o = (state_q == RESP);
      bus.resp_err_o   = (state_q == RESP) && err_q;
      bus.rf_wr_en_o   = load_done && (rd_q != 5'd0);
      bus.rf_rd_addr_o = '0;
      bus.rf_data_o    = '0;
      if (state_q != IDLE) bus.mem_addr_o = {addr_q[31:2], 2'b00};
      if (state_q == WR || (state_q == RESP && store_q && !err_q)) bus.mem_data_o = wr_word_q;
      if (load_done) begin
         bus.rf_rd_addr_o = rd_q;
         bus.rf_data_o    = load_q;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit wired to an 8 KiB word Memory model and a
// 32-entry Registers model.
module tb_load_store_unit;

   logic clk;
   logic rst_n;
   logic clr;
   logic no_ack;
   int   n_cmp;
   int   n_bad;

   lsu_if bus();

   load_store_unit #(.ACK_TIMEOUT(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem_w [0:2047];
   logic [31:0] regs  [0:31];
   logic        pend;
   logic [10:0] pend_idx;

   // Memory acks one cycle after it samples the read pulse.
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 2048; i++) mem_w[i] <= 32'h0;
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
         pend          <= 1'b0;
         pend_idx      <= '0;
         bus.mem_ack_i <= 1'b0;
         bus.mem_data_i <= 32'h0;
      end else begin
         bus.mem_ack_i  <= 1'b0;
         bus.mem_data_i <= 32'h0;
         if (pend && !no_ack) begin
            bus.mem_ack_i  <= 1'b1;
            bus.mem_data_i <= mem_w[pend_idx];
         end
         pend     <= bus.mem_rd_en_o;
         pend_idx <= bus.mem_addr_o[12:2];
         if (bus.mem_wr_en_o) mem_w[bus.mem_addr_o[12:2]] <= bus.mem_data_o;
         if (bus.rf_wr_en_o && bus.rf_rd_addr_o != 5'd0) regs[bus.rf_rd_addr_o] <= bus.rf_data_o;
      end
   end

   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd,
                         output int lat, output logic err, output int nrd, output int nwr,
                         output int nrf);
      lat = 0; err = 1'b0; nrd = 0; nwr = 0; nrf = 0;
      @(negedge clk);
      bus.req_store_i  = st;
      bus.req_funct3_i = f3;
      bus.req_addr_i   = a;
      bus.req_wdata_i  = wd;
      bus.req_rd_i     = rd;
      bus.req_valid_i  = 1'b1;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         nrd += int'(bus.mem_rd_en_o);
         nwr += int'(bus.mem_wr_en_o);
         nrf += int'(bus.rf_wr_en_o);
         if (bus.resp_valid_o) begin
            lat = c;
            err = bus.resp_err_o;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
      n_cmp++; if (bus.resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_resp: got %b want 0", bus.resp_valid_o); end
      n_cmp++; if ({bus.mem_rd_en_o, bus.mem_wr_en_o, bus.rf_wr_en_o} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {bus.mem_rd_en_o, bus.mem_wr_en_o, bus.rf_wr_en_o}); end
      n_cmp++; if (bus.mem_addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr_o); end
   endtask

   task automatic test_word();
      int lat, nrd, nwr, nrf; logic err;
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 2 || err !== 1'b0) begin n_bad++; $display("FAIL sw_lat: got lat %0d err %b want 2/0", lat, err); end
      n_cmp++; if (mem_w[4] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_word: got %h want deadbeef", mem_w[4]); end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd5, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 4 || err !== 1'b0 || nrd !== 1) begin n_bad++; $display("FAIL lw_lat: got lat %0d err %b rd %0d want 4/0/1", lat, err, nrd); end
      n_cmp++; if (regs[5] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_x5: got %h want deadbeef", regs[5]); end
   endtask

   task automatic test_byte();
      int lat, nrd, nwr, nrf; logic err;
      do_req(1'b1, 3'b000, 32'h11, 32'h1234567F, 5'd0, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 5 || nrd !== 1 || nwr !== 1) begin n_bad++; $display("FAIL sb_lat: got lat %0d rd %0d wr %0d want 5/1/1", lat, nrd, nwr); end
      n_cmp++; if (mem_w[4] !== 32'hDEAD7FEF) begin n_bad++; $display("FAIL sb_word: got %h want dead7fef", mem_w[4]); end
      do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd6, lat, err, nrd, nwr, nrf);
      n_cmp++; if (regs[6] !== 32'hFFFFFFDE) begin n_bad++; $display("FAIL lb: got %h want ffffffde", regs[6]); end
      do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd7, lat, err, nrd, nwr, nrf);
      n_cmp++; if (regs[7] !== 32'h000000DE) begin n_bad++; $display("FAIL lbu: got %h want 000000de", regs[7]); end
   endtask

   task automatic test_half();
      int lat, nrd, nwr, nrf; logic err;
      do_req(1'b1, 3'b001, 32'h12, 32'hABCD8001, 5'd0, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 5 || err !== 1'b0) begin n_bad++; $display("FAIL sh_lat: got lat %0d err %b want 5/0", lat, err); end
      n_cmp++; if (mem_w[4] !== 32'h80017FEF) begin n_bad++; $display("FAIL sh_word: got %h want 80017fef", mem_w[4]); end
      do_req(1'b0, 3'b001, 32'h12, 32'h0, 5'd8, lat, err, nrd, nwr, nrf);
      n_cmp++; if (regs[8] !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh: got %h want ffff8001", regs[8]); end
      do_req(1'b0, 3'b101, 32'h12, 32'h0, 5'd9, lat, err, nrd, nwr, nrf);
      n_cmp++; if (regs[9] !== 32'h00008001) begin n_bad++; $display("FAIL lhu: got %h want 00008001", regs[9]); end
   endtask

   task automatic test_misaligned();
      int lat, nrd, nwr, nrf; logic err;
      do_req(1'b0, 3'b010, 32'h12, 32'h0, 5'd10, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 1 || err !== 1'b1 || nrd + nwr + nrf !== 0) begin n_bad++; $display("FAIL lw_misal: got lat %0d err %b strobes %0d want 1/1/0", lat, err, nrd + nwr + nrf); end
      n_cmp++; if (regs[10] !== 32'h0) begin n_bad++; $display("FAIL lw_misal_rf: got %h want 0", regs[10]); end
      do_req(1'b0, 3'b001, 32'h11, 32'h0, 5'd11, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 1 || err !== 1'b1 || nrd + nwr + nrf !== 0) begin n_bad++; $display("FAIL lh_misal: got lat %0d err %b strobes %0d want 1/1/0", lat, err, nrd + nwr + nrf); end
      do_req(1'b1, 3'b010, 32'h13, 32'h55555555, 5'd0, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 1 || err !== 1'b1 || nrd + nwr !== 0) begin n_bad++; $display("FAIL sw_misal: got lat %0d err %b strobes %0d want 1/1/0", lat, err, nrd + nwr); end
      n_cmp++; if (mem_w[4] !== 32'h80017FEF) begin n_bad++; $display("FAIL sw_misal_mem: got %h want 80017fef", mem_w[4]); end
      do_req(1'b0, 3'b011, 32'h10, 32'h0, 5'd11, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 1 || err !== 1'b1 || nrd !== 0) begin n_bad++; $display("FAIL f3_illegal: got lat %0d err %b rd %0d want 1/1/0", lat, err, nrd); end
      do_req(1'b1, 3'b100, 32'h10, 32'h0, 5'd0, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 1 || err !== 1'b1 || nwr + nrd !== 0) begin n_bad++; $display("FAIL sbu_illegal: got lat %0d err %b strobes %0d want 1/1/0", lat, err, nwr + nrd); end
   endtask

   task automatic test_rd_zero();
      int lat, nrd, nwr, nrf; logic err;
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd0, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 4 || err !== 1'b0) begin n_bad++; $display("FAIL rd0_resp: got lat %0d err %b want 4/0", lat, err); end
      n_cmp++; if (nrf !== 0 || regs[0] !== 32'h0) begin n_bad++; $display("FAIL rd0_rf: got strobes %0d x0 %h want 0/0", nrf, regs[0]); end
   endtask

   task automatic test_timeout();
      int lat, nrd, nwr, nrf; logic err;
      no_ack = 1'b1;
      do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd12, lat, err, nrd, nwr, nrf);
      n_cmp++; if (lat !== 18 || err !== 1'b1) begin n_bad++; $display("FAIL timeout: got lat %0d err %b want 18/1", lat, err); end
      n_cmp++; if (nrf !== 0 || regs[12] !== 32'h0) begin n_bad++; $display("FAIL timeout_rf: got strobes %0d x12 %h want 0/0", nrf, regs[12]); end
      @(negedge clk);
      bus.req_store_i  = 1'b0;
      bus.req_funct3_i = 3'b010;
      bus.req_addr_i   = 32'h10;
      bus.req_rd_i     = 5'd13;
      bus.req_valid_i  = 1'b1;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.req_ready_o !== 1'b0 || bus.mem_addr_o !== 32'h10) begin n_bad++; $display("FAIL rd_wait_busy: got ready %b addr %h want 0/10", bus.req_ready_o, bus.mem_addr_o); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus.resp_valid_o, bus.resp_err_o, bus.mem_rd_en_o, bus.mem_wr_en_o, bus.rf_wr_en_o} !== 5'b0) begin n_bad++; $display("FAIL abort_strobes: got %b want 00000", {bus.resp_valid_o, bus.resp_err_o, bus.mem_rd_en_o, bus.mem_wr_en_o, bus.rf_wr_en_o}); end
      n_cmp++; if (bus.mem_addr_o !== 32'h0 || bus.mem_data_o !== 32'h0 || bus.rf_data_o !== 32'h0) begin n_bad++; $display("FAIL abort_bus: got addr %h data %h rf %h want 0", bus.mem_addr_o, bus.mem_data_o, bus.rf_data_o); end
      @(negedge clk);
      rst_n  = 1'b1;
      no_ack = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin n_bad++; $display("FAIL abort_release: got ready %b resp %b want 1/0", bus.req_ready_o, bus.resp_valid_o); end
      n_cmp++; if (regs[13] !== 32'h0) begin n_bad++; $display("FAIL abort_rf: got %h want 0", regs[13]); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      clr   = 1'b1;
      no_ack = 1'b0;
      rst_n = 1'b0;
      bus.req_valid_i  = 1'b0;
      bus.req_store_i  = 1'b0;
      bus.req_funct3_i = 3'b000;
      bus.req_addr_i   = 32'h0;
      bus.req_wdata_i  = 32'h0;
      bus.req_rd_i     = 5'd0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      clr   = 1'b0;
      @(negedge clk);
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misaligned();
      test_rd_zero();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
